// File: rtl/duart_pkg.sv
`default_nettype none
// ============================================================================
// duart_pkg : MC68681 channel-A register map, init table and host FSM states
// Revision  : 1.0
// ============================================================================
package duart_pkg;

  localparam logic [3:0] REG_MR  = 4'd0;
  localparam logic [3:0] REG_SR  = 4'd1;
  localparam logic [3:0] REG_CSR = 4'd1;
  localparam logic [3:0] REG_CR  = 4'd2;
  localparam logic [3:0] REG_RHR = 4'd3;
  localparam logic [3:0] REG_THR = 4'd3;
  localparam logic [3:0] REG_ACR = 4'd4;
  localparam logic [3:0] REG_ISR = 4'd5;
  localparam logic [3:0] REG_IMR = 4'd5;

  localparam int SR_RXRDY = 0;
  localparam int SR_TXRDY = 2;

  localparam logic [7:0] CMD_MR_PTR_RESET = 8'h10;
  localparam logic [7:0] CMD_RXTX_ENABLE  = 8'h05;
  localparam logic [7:0] IMR_RXRDYA       = 8'h02;
  localparam logic [2:0] INIT_LEN         = 3'd7;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } bus_cmd_t;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_RX_SR  = 3'd2,
    ST_RX_RHR = 3'd3,
    ST_TX_SR  = 3'd4,
    ST_TX_THR = 3'd5
  } top_state_t;

  function automatic bus_cmd_t init_cmd(input logic [2:0] step, input logic [7:0] mr1,
                                        input logic [7:0] mr2, input logic [7:0] csr,
                                        input logic [7:0] acr);
    bus_cmd_t c;
    case (step)
      3'd0:    c = '{addr: REG_CR,  data: CMD_MR_PTR_RESET};
      3'd1:    c = '{addr: REG_MR,  data: mr1};
      3'd2:    c = '{addr: REG_MR,  data: mr2};
      3'd3:    c = '{addr: REG_CSR, data: csr};
      3'd4:    c = '{addr: REG_ACR, data: acr};
      3'd5:    c = '{addr: REG_IMR, data: IMR_RXRDYA};
      default: c = '{addr: REG_CR,  data: CMD_RXTX_ENABLE};
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/duart_bus_cycle.sv
`default_nettype none
// ============================================================================
// duart_bus_cycle : one SETUP/STROBE/HOLD DUART host-bus access per start pulse
// Revision        : 1.0
// ============================================================================
module duart_bus_cycle #(
  parameter int STROBE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] data_in,
  output logic       idle,
  output logic       done,
  output logic [7:0] rdata,
  output logic [3:0] a,
  output logic       r_w,
  output logic       cs_n,
  output logic [7:0] data_out,
  output logic       data_oe
);

  localparam int CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_CYCLES - 1);

  typedef enum logic [1:0] {
    B_IDLE   = 2'd0,
    B_SETUP  = 2'd1,
    B_STROBE = 2'd2,
    B_HOLD   = 2'd3
  } bus_state_t;

  bus_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       a_nx;
  logic             rw_nx, cs_nx, oe_nx;
  logic [7:0]       dout_nx, rdata_nx;

  assign idle = (state == B_IDLE);
  assign done = (state == B_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= B_IDLE;
      cnt      <= '0;
      a        <= '0;
      r_w      <= 1'b1;
      cs_n     <= 1'b1;
      data_out <= '0;
      data_oe  <= 1'b0;
      rdata    <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      a        <= a_nx;
      r_w      <= rw_nx;
      cs_n     <= cs_nx;
      data_out <= dout_nx;
      data_oe  <= oe_nx;
      rdata    <= rdata_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    a_nx     = a;
    rw_nx    = r_w;
    cs_nx    = cs_n;
    dout_nx  = data_out;
    oe_nx    = data_oe;
    rdata_nx = rdata;
    unique case (state)
      B_IDLE, B_HOLD: begin
        // A start during HOLD chains the next access with no idle gap
        if (start) begin
          state_nx = B_SETUP;
          a_nx     = addr;
          rw_nx    = rw;
          dout_nx  = rw ? 8'h00 : wdata;
          oe_nx    = !rw;
          cs_nx    = 1'b1;
        end else if (state == B_HOLD) begin
          state_nx = B_IDLE;
          rw_nx    = 1'b1;
          dout_nx  = 8'h00;
          oe_nx    = 1'b0;
        end
      end
      B_SETUP: begin
        state_nx = B_STROBE;
        cs_nx    = 1'b0;
        cnt_nx   = '0;
      end
      B_STROBE: begin
        if (cnt == CNT_LAST) begin
          state_nx = B_HOLD;
          cs_nx    = 1'b1;
          if (r_w) rdata_nx = data_in;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/duart_host_controller.sv
`default_nettype none
// ============================================================================
// duart_host_controller : DUART channel-A init sequencer plus RX/TX service arbiter
// Revision              : 1.0
// ============================================================================
module duart_host_controller
  import duart_pkg::*;
#(
  parameter int         STROBE_CYCLES = 2,
  parameter logic [7:0] CSR_VAL       = 8'hBB,
  parameter logic [7:0] ACR_VAL       = 8'h80,
  parameter logic [7:0] MR1_VAL       = 8'h13,
  parameter logic [7:0] MR2_VAL       = 8'h07
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       INIT_DONE,
  output logic [3:0] A,
  output logic       R_W,
  output logic       _CS,
  output logic [7:0] DATA_OUT,
  output logic       DATA_OE,
  input  logic [7:0] DATA_IN,
  input  logic       _INT
);

  top_state_t state, state_nx;
  logic [2:0] step, step_nx;
  logic       last_rx, last_rx_nx;
  logic       init_done_nx, rx_valid_nx;
  logic [7:0] rx_data_nx;
  logic       rx_pend, tx_pend;
  logic       bus_start, bus_rw, bus_idle, bus_done;
  logic [3:0] bus_addr;
  logic [7:0] bus_wdata, bus_rdata;
  bus_cmd_t   cmd;

  duart_bus_cycle #(.STROBE_CYCLES(STROBE_CYCLES)) u_bus (
    .clk      (CLK),
    .rst      (RESET),
    .start    (bus_start),
    .rw       (bus_rw),
    .addr     (bus_addr),
    .wdata    (bus_wdata),
    .data_in  (DATA_IN),
    .idle     (bus_idle),
    .done     (bus_done),
    .rdata    (bus_rdata),
    .a        (A),
    .r_w      (R_W),
    .cs_n     (_CS),
    .data_out (DATA_OUT),
    .data_oe  (DATA_OE)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_INIT;
      step      <= '0;
      last_rx   <= 1'b0;
      INIT_DONE <= 1'b0;
      RX_VALID  <= 1'b0;
      RX_DATA   <= '0;
    end else begin
      state     <= state_nx;
      step      <= step_nx;
      last_rx   <= last_rx_nx;
      INIT_DONE <= init_done_nx;
      RX_VALID  <= rx_valid_nx;
      RX_DATA   <= rx_data_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    step_nx      = step;
    last_rx_nx   = last_rx;
    init_done_nx = INIT_DONE;
    rx_valid_nx  = 1'b0;
    rx_data_nx   = RX_DATA;
    bus_start    = 1'b0;
    bus_rw       = 1'b1;
    bus_addr     = REG_SR;
    bus_wdata    = 8'h00;
    TX_READY     = 1'b0;
    rx_pend      = !_INT;
    tx_pend      = TX_VALID;
    cmd          = init_cmd(step, MR1_VAL, MR2_VAL, CSR_VAL, ACR_VAL);
    unique case (state)
      ST_INIT: begin
        // step counts table writes already issued
        if (step != INIT_LEN && (bus_idle || bus_done)) begin
          bus_start = 1'b1;
          bus_rw    = 1'b0;
          bus_addr  = cmd.addr;
          bus_wdata = cmd.data;
          step_nx   = step + 3'd1;
        end else if (bus_done) begin
          state_nx     = ST_IDLE;
          init_done_nx = 1'b1;
        end
      end
      ST_IDLE: begin
        // last_rx only moves on contention, so the first tie goes to RX
        if (rx_pend && (!tx_pend || !last_rx)) begin
          bus_start = 1'b1;
          state_nx  = ST_RX_SR;
          if (tx_pend) last_rx_nx = 1'b1;
        end else if (tx_pend) begin
          bus_start = 1'b1;
          state_nx  = ST_TX_SR;
          if (rx_pend) last_rx_nx = 1'b0;
        end
      end
      ST_RX_SR: begin
        if (bus_done) begin
          if (bus_rdata[SR_RXRDY]) begin
            bus_start = 1'b1;
            bus_addr  = REG_RHR;
            state_nx  = ST_RX_RHR;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      ST_RX_RHR: begin
        if (bus_done) begin
          state_nx    = ST_IDLE;
          rx_valid_nx = 1'b1;
          rx_data_nx  = bus_rdata;
        end
      end
      ST_TX_SR: begin
        if (bus_done) begin
          if (bus_rdata[SR_TXRDY]) begin
            bus_start = 1'b1;
            bus_rw    = 1'b0;
            bus_addr  = REG_THR;
            bus_wdata = TX_DATA;
            state_nx  = ST_TX_THR;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      ST_TX_THR: begin
        TX_READY = bus_done;
        if (bus_done) state_nx = ST_IDLE;
      end
      default: state_nx = ST_INIT;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_duart_host_controller.sv
`default_nettype none
// ============================================================================
// tb_duart_host_controller : directed bench with a behavioural DUART channel-A model
// Revision                 : 1.0
// ============================================================================
module tb_duart_host_controller;

  typedef struct packed {
    logic [3:0] a;
    logic       rw;
    logic       oe;
    logic [7:0] d;
  } acc_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, rx_valid, init_done, r_w, cs_n, data_oe, int_n;
  logic [7:0] rx_data, data_out, data_in, sra;
  logic [3:0] a;

  // DUART model state
  logic       txrdy = 1'b0;
  logic [7:0] rhr = 8'h00;
  logic       rxrdy;
  logic       prev_cs = 1'b1;
  int         tx_gate = 0, sr_reads = 0, rhr_reads = 0, rx_posted = 0;
  int         tx_cnt = 0, rx_cnt = 0;
  acc_t       log_q[$];

  int checks = 0, failures = 0;
  int base, tb0, rb0, k;

  logic [3:0] init_a [7] = '{4'd2, 4'd0, 4'd0, 4'd1, 4'd4, 4'd5, 4'd2};
  logic [7:0] init_d [7] = '{8'h10, 8'h13, 8'h07, 8'hBB, 8'h80, 8'h02, 8'h05};

  duart_host_controller dut (
    .CLK       (clk),
    .RESET     (rst),
    .TX_DATA   (tx_data),
    .TX_VALID  (tx_valid),
    .TX_READY  (tx_ready),
    .RX_DATA   (rx_data),
    .RX_VALID  (rx_valid),
    .INIT_DONE (init_done),
    .A         (a),
    .R_W       (r_w),
    ._CS       (cs_n),
    .DATA_OUT  (data_out),
    .DATA_OE   (data_oe),
    .DATA_IN   (data_in),
    ._INT      (int_n)
  );

  always #5 clk = ~clk;

  assign rxrdy   = (rx_posted != rhr_reads);
  assign int_n   = !rxrdy;
  assign sra     = {5'b0, txrdy && (sr_reads >= tx_gate), 1'b0, rxrdy};
  assign data_in = (a == 4'd1) ? sra : (a == 4'd3) ? rhr : 8'h00;

  // Bus monitor and model side effects, sampled on the falling edge
  always @(negedge clk) begin
    prev_cs <= cs_n;
    if (prev_cs && !cs_n) begin
      log_q.push_back('{a: a, rw: r_w, oe: data_oe, d: (data_oe ? data_out : 8'h00)});
      if (r_w && a == 4'd3) rhr_reads <= rhr_reads + 1;
    end
    if (!prev_cs && cs_n && r_w && a == 4'd1) sr_reads <= sr_reads + 1;
    if (tx_ready) tx_cnt <= tx_cnt + 1;
    if (rx_valid) rx_cnt <= rx_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_acc(input string tag, input int idx, input logic [3:0] ea,
                           input logic erw, input logic [7:0] ed);
    acc_t e;
    e = '{a: ea, rw: erw, oe: !erw, d: (erw ? 8'h00 : ed)};
    check({tag, "_present"}, 32'(log_q.size() > idx), 32'd1);
    if (log_q.size() > idx) check(tag, 32'(log_q[idx]), 32'(e));
  endtask

  task automatic wait_tx(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (tx_ready) begin n = i; break; end
    end
  endtask

  task automatic wait_rx(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (rx_valid) begin n = i; break; end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cs", cs_n, 1);
    check("rst_rw", r_w, 1);
    check("rst_a", a, 0);
    check("rst_bus_data", {data_oe, data_out}, 0);
    check("rst_flags", {tx_ready, rx_valid, init_done}, 0);
    check("rst_rx_data", rx_data, 0);

    // Init table after reset release
    base = log_q.size();
    rst  = 1'b0;
    repeat (28) @(negedge clk);
    check("init_done_c28", init_done, 0);
    @(negedge clk);
    check("init_done_c29", init_done, 1);
    check("init_count", log_q.size() - base, 7);
    for (int i = 0; i < 7; i++) check_acc($sformatf("init_w%0d", i), base + i, init_a[i], 1'b0, init_d[i]);

    // Single transmit, TxRDY already set
    base = log_q.size(); tb0 = tx_cnt;
    txrdy = 1'b1; tx_gate = sr_reads; tx_data = 8'h41; tx_valid = 1'b1;
    wait_tx(k);
    tx_valid = 1'b0;
    check("tx_latency", k, 8);
    repeat (4) @(negedge clk);
    check("tx_pulses", tx_cnt - tb0, 1);
    check("tx_count", log_q.size() - base, 2);
    check_acc("tx_sr", base, 4'd1, 1'b1, 8'h00);
    check_acc("tx_thr", base + 1, 4'd3, 1'b0, 8'h41);

    // Single receive
    base = log_q.size(); rb0 = rx_cnt;
    txrdy = 1'b0; rhr = 8'h5A; rx_posted++;
    wait_rx(k);
    check("rx_latency", k, 9);
    check("rx_data", rx_data, 8'h5A);
    repeat (4) @(negedge clk);
    check("rx_pulses", rx_cnt - rb0, 1);
    check("rx_count", log_q.size() - base, 2);
    check_acc("rx_sr", base, 4'd1, 1'b1, 8'h00);
    check_acc("rx_rhr", base + 1, 4'd3, 1'b1, 8'h00);

    // First contention: RX wins
    base = log_q.size();
    txrdy = 1'b1; tx_gate = sr_reads; rhr = 8'hA5; rx_posted++;
    tx_data = 8'h33; tx_valid = 1'b1;
    wait_rx(k);
    check("c1_rx_latency", k, 9);
    check("c1_rx_data", rx_data, 8'hA5);
    wait_tx(k);
    tx_valid = 1'b0;
    check("c1_tx_after_rx", k, 8);
    check("c1_count", log_q.size() - base, 4);
    check_acc("c1_acc0", base, 4'd1, 1'b1, 8'h00);
    check_acc("c1_acc1", base + 1, 4'd3, 1'b1, 8'h00);
    check_acc("c1_acc2", base + 2, 4'd1, 1'b1, 8'h00);
    check_acc("c1_acc3", base + 3, 4'd3, 1'b0, 8'h33);
    repeat (3) @(negedge clk);

    // Second contention: TX wins
    base = log_q.size();
    rhr = 8'hC3; rx_posted++; tx_data = 8'h77; tx_valid = 1'b1;
    wait_tx(k);
    tx_valid = 1'b0;
    check("c2_tx_latency", k, 8);
    wait_rx(k);
    check("c2_rx_after_tx", k, 10);
    check("c2_rx_data", rx_data, 8'hC3);
    check("c2_count", log_q.size() - base, 4);
    check_acc("c2_acc0", base, 4'd1, 1'b1, 8'h00);
    check_acc("c2_acc1", base + 1, 4'd3, 1'b0, 8'h77);
    check_acc("c2_acc2", base + 2, 4'd1, 1'b1, 8'h00);
    check_acc("c2_acc3", base + 3, 4'd3, 1'b1, 8'h00);
    repeat (3) @(negedge clk);

    // TxRDY low for three polls
    base = log_q.size(); tb0 = tx_cnt;
    txrdy = 1'b1; tx_gate = sr_reads + 3; tx_data = 8'h99; tx_valid = 1'b1;
    wait_tx(k);
    tx_valid = 1'b0;
    check("poll_latency", k, 23);
    repeat (4) @(negedge clk);
    check("poll_tx_pulses", tx_cnt - tb0, 1);
    check("poll_count", log_q.size() - base, 5);
    for (int i = 0; i < 4; i++) check_acc($sformatf("poll_sr%0d", i), base + i, 4'd1, 1'b1, 8'h00);
    check_acc("poll_thr", base + 4, 4'd3, 1'b0, 8'h99);

    // Reset in the middle of an init STROBE
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_strobe_cs", cs_n, 0);
    #1 rst = 1'b1;
    #1;
    check("async_cs", cs_n, 1);
    check("async_bus", {r_w, data_oe, a}, 6'b100000);
    check("async_init_done", init_done, 0);
    @(negedge clk);
    rst  = 1'b0;
    base = log_q.size();
    repeat (29) @(negedge clk);
    check("replay_init_done", init_done, 1);
    check("replay_count", log_q.size() - base, 7);
    for (int i = 0; i < 7; i++) check_acc($sformatf("replay_w%0d", i), base + i, init_a[i], 1'b0, init_d[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
